bootloader_loader: RTL

Byte-stream writer that fills the instruction memory from a host link before execution starts. Sits between the UART receiver and the instruction-fetch stage: it takes received bytes, drives the fetch stage's bootloader byte/write-enable inputs one byte per pulse, detects the end-of-program word, and then resets the PC so the loaded program starts at address 0.

---
 rtl/bootloader_loader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bootloader_loader.sv
// Streams host bytes into instruction memory after a load command and stops at the HALT word.
// Each accepted byte produces a one-cycle write strobe on the next cycle; there is no backpressure.
module bootloader_loader #(
  parameter int                 NB_DATA   = 32,
  parameter int                 NB_BYTE   = 8,
  parameter int                 MEM_BYTES = 256,
  parameter logic [NB_BYTE-1:0] CMD_LOAD  = 8'h4C,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF,
  localparam int                NB_COUNT  = $clog2(MEM_BYTES) + 1
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_rx_done,
  input  logic                i_restart,
  output logic [NB_BYTE-1:0]  o_byte_de_bootloader,
  output logic                o_bootloader_write_enable,
  output logic                o_pc_reset,
  output logic                o_load_done,
  output logic                o_error,
  output logic [NB_COUNT-1:0] o_byte_count
);

  localparam int                  BYTES_PER_WORD = NB_DATA / NB_BYTE;
  localparam int                  WORD_SEL       = $clog2(BYTES_PER_WORD);
  localparam int                  NB_SHIFT       = NB_DATA - NB_BYTE;
  localparam logic [NB_COUNT-1:0] COUNT_FULL     = NB_COUNT'(MEM_BYTES);
  localparam logic [WORD_SEL-1:0] LAST_LANE      = WORD_SEL'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [NB_COUNT-1:0]   count_q, count_d;
  logic [NB_SHIFT-1:0]   shift_q, shift_d;
  logic [NB_BYTE-1:0]    byte_q, byte_d;
  logic                  we_q, we_d;
  logic                  pc_pend_q, pc_pend_d;
  logic                  pc_reset_q, pc_reset_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [NB_DATA-1:0]    word_nxt;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    shift_d    = shift_q;
    byte_d     = byte_q;
    we_d       = 1'b0;
    pc_pend_d  = 1'b0;
    // Delay the PC reset one extra cycle so it lands after the final memory write.
    pc_reset_d = pc_pend_q;
    word_nxt   = {shift_q, i_rx_data};

    case (state_q)
      ST_IDLE: begin
        if (i_rx_done && (i_rx_data == CMD_LOAD)) begin
          state_d = ST_LOAD;
          count_d = '0;
          shift_d = '0;
        end
      end
      ST_LOAD: begin
        if (i_rx_done) begin
          if (count_q == COUNT_FULL) begin
            state_d = ST_ERROR;
          end else begin
            byte_d  = i_rx_data;
            we_d    = 1'b1;
            count_d = count_q + NB_COUNT'(1);
            shift_d = word_nxt[NB_SHIFT-1:0];
            // HALT is only recognised on a word-aligned boundary and is itself written.
            if ((count_q[WORD_SEL-1:0] == LAST_LANE) && (word_nxt == HALT_WORD)) begin
              state_d   = ST_DONE;
              pc_pend_d = 1'b1;
            end
          end
        end
      end
      ST_DONE, ST_ERROR: begin
        if (i_restart) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      shift_q    <= '0;
      byte_q     <= '0;
      we_q       <= 1'b0;
      pc_pend_q  <= 1'b0;
      pc_reset_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      byte_q     <= byte_d;
      we_q       <= we_d;
      pc_pend_q  <= pc_pend_d;
      pc_reset_q <= pc_reset_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign o_byte_de_bootloader      = byte_q;
  assign o_bootloader_write_enable = we_q;
  assign o_pc_reset                = pc_reset_q;
  assign o_load_done               = done_q;
  assign o_error                   = error_q;
  assign o_byte_count              = count_q;

endmodule
